alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Two-register execute wrapper that sits directly upstream of the 32-bit ALU.
- Accepts ALU commands over a valid/ready handshake and decodes the 4-bit ALU control code into the ALU's 3-bit op (op[2] = binv, op[1:0] = AND/OR/ADD/SLT).
- Stage 1 holds the operands and drives the ALU. Stage 2 captures the ALU result and zero flag and presents them downstream with valid/ready backpressure.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU width.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  stage 1 can accept a command this cycle.
- in_ctl  input  4  ALU control code.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_fwd_a  input  1  take A from the previous result (ALU_FWD_EN only).
- in_fwd_b  input  1  take B from the previous result (ALU_FWD_EN only).
- alu_a  output  WIDTH  registered operand A to the ALU.
- alu_b  output  WIDTH  registered operand B to the ALU.
- alu_op  output  3  registered op to the ALU.
- alu_result  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero  input  1  ALU zero flag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  registered result.
- out_zero  output  1  registered zero flag.
- out_illegal  output  1  registered: command used an unsupported in_ctl.

Behaviour:
- Reset: Rst_n = 0 at a rising edge clears all of the following, and any in-flight commands are discarded:
  - s1_valid = 0 and s2_valid = 0 (out_valid = 0).
  - alu_a = 0, alu_b = 0, alu_op = 3'b010.
  - out_result = 0, out_zero = 0, out_illegal = 0.
  - last_result = 0.
  - in_ready is combinational and is 1 while reset holds.
- Decode of in_ctl:
  - 0000 -> 000 (AND)
  - 0001 -> 001 (OR)
  - 0010 -> 010 (ADD)
  - 0110 -> 110 (SUB)
  - 0111 -> 111 (SLT)
  - Any other code -> 010 (ADD), with the illegal bit set and carried through stage 1.
- Handshake:
  - s2_free = !s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !s1_valid | s1_adv (combinational; no combinational path from in_valid to in_ready).
- Stage 1 capture (in_valid & in_ready): load alu_a, alu_b, alu_op and the illegal bit; set s1_valid. Otherwise, if s1_adv, clear s1_valid.
- Stage 2 capture (s1_adv):
  - Load out_result = alu_result, out_zero = alu_zero, out_illegal = the stage 1 illegal bit.
  - Set s2_valid; last_result <= alu_result.
  - If out_ready is high and no s1_adv occurs, clear s2_valid.
- Latency and throughput:
  - Accept to out_valid is 2 cycles.
  - Sustained throughput is 1 command per cycle while out_ready = 1.
  - Ordering is strictly in order; no drops, no duplicates.
- Boundary cases:
  - Full: s1 and s2 both valid with out_ready = 0 -> in_ready = 0 and all registers hold.
  - Full with out_ready = 1: stage 2 drains, stage 1 moves to stage 2 and a new command enters, all in the same cycle.
  - Empty: outputs hold their last values; out_valid = 0.
  - Results outside stage 2 capture: out_result is valid only while out_valid = 1.
- Arithmetic: the ALU's ADD and SUB wrap modulo 2^WIDTH; this stage performs no arithmetic and no overflow detection.

Optional Feature:
- Macro: ALU_FWD_EN.
- With ALU_FWD_EN defined, when in_fwd_a or in_fwd_b is set, the stage 1 capture of that operand uses the result of the immediately preceding command:
  - If s1_valid (which implies s1_adv during the capture), use the live alu_result.
  - Otherwise use last_result.
- Without ALU_FWD_EN:
  - in_fwd_a and in_fwd_b are ignored; operands always come from in_a and in_b.
  - The last_result register is removed.

Test Plan:
- Reset then ADD, in_ctl=0010, a=5, b=7, out_ready=1 -> out_valid two cycles after accept; out_result=12, out_zero=0, out_illegal=0.
- SUB, in_ctl=0110, a=9, b=9 -> out_result=0, out_zero=1. Separately, SLT with in_ctl=0111, a=3, b=8 -> out_result=1.
- Back-to-back: AND 0xF0F0F0F0 & 0xFF00FF00, then OR of the same operands, then ADD 0xFFFFFFFF+1 -> three results on consecutive cycles: 0xF000F000, 0xFFF0FFF0, 0x00000000 (zero=1).
- Backpressure: out_ready=0 with 3 commands offered -> 2 accepted, in_ready=0, outputs stable. Then out_ready=1 -> both results delivered in order, third command accepted the same cycle stage 1 advances.
- Illegal in_ctl=1100 with a=2, b=3 -> out_illegal=1, out_result=5. Separately, Rst_n=0 mid-flight -> out_valid=0 the next cycle and the in-flight commands are never delivered.
- ALU_FWD_EN: ADD 4+6, then next cycle in_fwd_a=1, b=1, ADD -> second out_result=11. Repeat after pipeline idle -> forwarded value comes from last_result (11).

Source files
------------

// File: rtl/alu_issue_stage.sv
// Two-register execute wrapper in front of the 32-bit ALU: stage 1 drives the ALU, stage 2 holds its result.
// Optional result forwarding into the operand capture is enabled by defining ALU_FWD_EN.
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_fwd_a,
  input  logic             in_fwd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal
);

  logic             s1_valid_q, s1_valid_d;
  logic             s1_ill_q, s1_ill_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  logic             s2_free, s1_adv, s1_take;
  logic [2:0]       dec_op;
  logic             dec_ill;
  logic [WIDTH-1:0] a_sel, b_sel;

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !Rst_n || !s1_valid_q || s1_adv;
  assign s1_take  = in_valid && in_ready;

  // Unsupported codes still execute as ADD; only the illegal flag marks them.
  always_comb begin
    dec_op  = 3'b010;
    dec_ill = 1'b0;
    case (in_ctl)
      4'b0000: dec_op = 3'b000;
      4'b0001: dec_op = 3'b001;
      4'b0010: dec_op = 3'b010;
      4'b0110: dec_op = 3'b110;
      4'b0111: dec_op = 3'b111;
      default: dec_ill = 1'b1;
    endcase
  end

`ifdef ALU_FWD_EN
  logic [WIDTH-1:0] last_result_q, last_result_d;
  logic [WIDTH-1:0] fwd_val;

  // A live stage 1 command is the predecessor; otherwise it already left via stage 2.
  assign fwd_val = s1_valid_q ? alu_result : last_result_q;
  assign a_sel   = in_fwd_a ? fwd_val : in_a;
  assign b_sel   = in_fwd_b ? fwd_val : in_b;
  assign last_result_d = s1_adv ? alu_result : last_result_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      last_result_q <= '0;
    end else begin
      last_result_q <= last_result_d;
    end
  end
`else
  logic unused_fwd;

  assign a_sel      = in_a;
  assign b_sel      = in_b;
  assign unused_fwd = in_fwd_a ^ in_fwd_b;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ill_d   = s1_ill_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    zero_d     = zero_q;
    ill_d      = ill_q;

    if (s1_take) begin
      s1_valid_d = 1'b1;
      s1_ill_d   = dec_ill;
      alu_a_d    = a_sel;
      alu_b_d    = b_sel;
      alu_op_d   = dec_op;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      res_d      = alu_result;
      zero_d     = alu_zero;
      ill_d      = s1_ill_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ill_q   <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 3'b010;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ill_q   <= s1_ill_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      ill_q      <= ill_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign out_valid   = s2_valid_q;
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU plus a two-slot pipeline model checked every cycle.
// Build with ALU_FWD_EN defined to exercise operand forwarding.
module tb_alu_issue_stage;

`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_ctl;
  logic [31:0] in_a, in_b;
  logic        in_fwd_a, in_fwd_b;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_illegal;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 Clk = ~Clk;

  alu_issue_stage #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctl(in_ctl),
    .in_a(in_a), .in_b(in_b), .in_fwd_a(in_fwd_a), .in_fwd_b(in_fwd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  // Stand-in for the downstream ALU.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = {31'b0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  typedef struct packed { logic il; logic z; logic [31:0] r; } rr_t;
  typedef struct { logic [31:0] res; logic z; logic il; int pos; int acc; } ent_t;
  typedef struct { logic [31:0] res; logic z; logic il; int lat; int cyc; } got_t;

  ent_t        q[$];
  got_t        got[$];
  logic [31:0] prev_res = 32'h0;
  logic [31:0] hold_res = 32'h0;
  logic        hold_z   = 1'b0;
  logic        hold_i   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rr_t ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    rr_t o;
    o.il = 1'b0;
    case (c)
      4'd0:    o.r = a & b;
      4'd1:    o.r = a | b;
      4'd2:    o.r = a + b;
      4'd6:    o.r = a - b;
      4'd7:    o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin o.r = a + b; o.il = 1'b1; end
    endcase
    o.z = (o.r == 32'h0);
    return o;
  endfunction

  // Pipeline model: entry pos 1 = stage 1, pos 2 = stage 2; oldest first.
  always @(negedge Clk) begin
    logic  s1occ, s2occ, exp_rdy;
    ent_t  e;
    got_t  g;
    rr_t   r;
    logic [31:0] oa, ob;
    cyc++;
    if (!Rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      prev_res = 32'h0;
      hold_res = 32'h0;
      hold_z   = 1'b0;
      hold_i   = 1'b0;
    end else begin
      s2occ   = (q.size() > 0) && (q[0].pos == 2);
      s1occ   = (q.size() > 0) && (q[q.size()-1].pos == 1);
      exp_rdy = !s1occ || !s2occ || out_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(s2occ));
      if (s2occ) begin
        chk("out_result", out_result, q[0].res);
        chk("out_zero", 32'(out_zero), 32'(q[0].z));
        chk("out_illegal", 32'(out_illegal), 32'(q[0].il));
      end else begin
        chk("hold_result", out_result, hold_res);
        chk("hold_zero", 32'(out_zero), 32'(hold_z));
        chk("hold_illegal", 32'(out_illegal), 32'(hold_i));
      end
      if (s2occ && out_ready) begin
        e = q.pop_front();
        g.res = e.res; g.z = e.z; g.il = e.il; g.lat = cyc - e.acc; g.cyc = cyc;
        got.push_back(g);
        hold_res = e.res; hold_z = e.z; hold_i = e.il;
      end
      if (q.size() > 0 && q[0].pos == 1) begin
        e = q[0];
        e.pos = 2;
        q[0] = e;
      end
      if (in_valid && exp_rdy) begin
        oa = (FWD && in_fwd_a) ? prev_res : in_a;
        ob = (FWD && in_fwd_b) ? prev_res : in_b;
        r  = ref_op(in_ctl, oa, ob);
        e.res = r.r; e.z = r.z; e.il = r.il; e.pos = 1; e.acc = cyc;
        q.push_back(e);
        prev_res = r.r;
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic fa, input logic fb);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_ctl = c; in_a = a; in_b = b; in_fwd_a = fa; in_fwd_b = fb;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      acc = in_ready;
      @(posedge Clk);
      #2;
      if (acc) break;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got no accept expected accept within 30 cycles");
    end
    in_valid = 1'b0; in_fwd_a = 1'b0; in_fwd_b = 1'b0;
  endtask

  task automatic drain();
    logic empty;
    empty = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      #1;
      empty = (q.size() == 0);
      @(posedge Clk);
      #2;
      if (empty) break;
    end
    if (!empty) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic expect_got(input string name, input int idx, input logic [31:0] res,
                            input logic z, input logic il);
    chk({name, "_count"}, 32'(got.size() > idx), 32'd1);
    if (got.size() > idx) begin
      chk({name, "_res"}, got[idx].res, res);
      chk({name, "_zero"}, 32'(got[idx].z), 32'(z));
      chk({name, "_ill"}, 32'(got[idx].il), 32'(il));
    end
  endtask

  initial begin
    int b;
    Rst_n = 1'b0; in_valid = 1'b0; in_ctl = 4'd0; in_a = '0; in_b = '0;
    in_fwd_a = 1'b0; in_fwd_b = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #2 Rst_n = 1'b1;
    @(negedge Clk);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_b", alu_b, 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd2);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_flags", {30'b0, out_zero, out_illegal}, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge Clk); #2;

    b = got.size();
    send(4'b0010, 32'd5, 32'd7, 1'b0, 1'b0);
    drain();
    expect_got("add", b, 32'd12, 1'b0, 1'b0);
    if (got.size() > b) chk("add_latency", 32'(got[b].lat), 32'd2);

    b = got.size();
    send(4'b0110, 32'd9, 32'd9, 1'b0, 1'b0);
    drain();
    send(4'b0111, 32'd3, 32'd8, 1'b0, 1'b0);
    drain();
    send(4'b0111, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    drain();
    expect_got("sub", b, 32'd0, 1'b1, 1'b0);
    expect_got("slt", b + 1, 32'd1, 1'b0, 1'b0);
    expect_got("slt_neg", b + 2, 32'd1, 1'b0, 1'b0);

    b = got.size();
    send(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);
    send(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    drain();
    expect_got("b2b_and", b, 32'hF000_F000, 1'b0, 1'b0);
    expect_got("b2b_or", b + 1, 32'hFFF0_FFF0, 1'b0, 1'b0);
    expect_got("b2b_add", b + 2, 32'h0, 1'b1, 1'b0);
    if (got.size() > b + 2) begin
      chk("b2b_gap1", 32'(got[b+1].cyc - got[b].cyc), 32'd1);
      chk("b2b_gap2", 32'(got[b+2].cyc - got[b+1].cyc), 32'd1);
    end

    b = got.size();
    out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd1, 1'b0, 1'b0);
    send(4'b0010, 32'd2, 32'd2, 1'b0, 1'b0);
    in_valid = 1'b1; in_ctl = 4'b0010; in_a = 32'd3; in_b = 32'd3;
    repeat (3) begin
      @(negedge Clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_result", out_result, 32'd2);
      @(posedge Clk); #2;
    end
    out_ready = 1'b1;
    @(negedge Clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge Clk); #2;
    in_valid = 1'b0;
    drain();
    expect_got("bp_first", b, 32'd2, 1'b0, 1'b0);
    expect_got("bp_second", b + 1, 32'd4, 1'b0, 1'b0);
    expect_got("bp_third", b + 2, 32'd6, 1'b0, 1'b0);

    b = got.size();
    send(4'b1100, 32'd2, 32'd3, 1'b0, 1'b0);
    drain();
    expect_got("illegal", b, 32'd5, 1'b0, 1'b1);

    b = got.size();
    out_ready = 1'b0;
    send(4'b0010, 32'd10, 32'd1, 1'b0, 1'b0);
    send(4'b0010, 32'd20, 32'd2, 1'b0, 1'b0);
    Rst_n = 1'b0;
    @(posedge Clk); #2;
    Rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge Clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    @(posedge Clk); #2;
    repeat (5) @(posedge Clk);
    #2;
    chk("midrst_no_delivery", 32'(got.size()), 32'(b));

    b = got.size();
`ifdef ALU_FWD_EN
    send(4'b0010, 32'd4, 32'd6, 1'b0, 1'b0);
    send(4'b0010, 32'h99, 32'd1, 1'b1, 1'b0);
    drain();
    repeat (3) @(posedge Clk);
    #2;
    send(4'b0010, 32'h77, 32'd1, 1'b1, 1'b0);
    drain();
    send(4'b0110, 32'd20, 32'h55, 1'b0, 1'b1);
    drain();
    expect_got("fwd_base", b, 32'd10, 1'b0, 1'b0);
    expect_got("fwd_live", b + 1, 32'd11, 1'b0, 1'b0);
    expect_got("fwd_last", b + 2, 32'd12, 1'b0, 1'b0);
    expect_got("fwd_b", b + 3, 32'd8, 1'b0, 1'b0);
`else
    send(4'b0010, 32'd1, 32'd2, 1'b1, 1'b1);
    drain();
    expect_got("fwd_ignored", b, 32'd3, 1'b0, 1'b0);
`endif

    repeat (2) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
